// File: rtl/v3_pulse_gen_pkg.sv
// v3_pulse_gen_pkg
// Shared settings for the pulse generator slice of the trapezoidal shaping
// chain: filter sample width, pulse FSM state encoding and the noise LFSR
// constants.
package v3_pulse_gen_pkg;

  // Sample width of the shaping filter input; the generator matches it.
  localparam int SIZE_FILTER_DATA = 16;
  localparam int PG_DATA_W        = SIZE_FILTER_DATA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } pg_state_t;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1: feedback taps are bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/v3_lfsr16.sv
// v3_lfsr16
// 16-bit Fibonacci LFSR used as a cheap noise source for the pulse
// generator. Reloads the seed on reset and shifts once per enable.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset (loads LFSR_SEED)
//   en    - advance one step
//   q     - current LFSR state
module v3_lfsr16
  import v3_pulse_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/v3_pulse_gen.sv
// v3_pulse_gen
// Synthetic detector-pulse source feeding the trapezoidal filter input.
// A pulse is a linear rise over RISE_LEN samples to the requested amplitude
// followed by an exponential decay (acc -= acc >>> DECAY_SHIFT) that ends
// once the per-sample decrement reaches 0 or -1. One sample per sample_en.
// Optional noise: define V3_PULSE_GEN_NOISE_EN to add the signed low
// NOISE_BITS bits of a 16-bit LFSR to each sample before saturation.
// Ports:
//   clk        - clock
//   reset      - synchronous, active-high reset
//   trig       - pulse start request (level)
//   trig_ack   - combinational accept: trig while idle and not in reset
//   trig_amp   - signed amplitude, captured on trig_ack
//   baseline   - signed offset added live to every sample
//   sample_en  - produce one sample
//   out_data   - registered, saturated sample
//   out_valid  - registered copy of sample_en
//   busy       - registered, high while a pulse is in progress
//   pulse_done - one-cycle strobe with the terminating decay sample
module v3_pulse_gen
  import v3_pulse_gen_pkg::*;
#(
  parameter int DATA_W      = PG_DATA_W,
  parameter int RISE_LEN    = 4,
  parameter int DECAY_SHIFT = 4,
  parameter int NOISE_BITS  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trig,
  output logic                     trig_ack,
  input  logic signed [DATA_W-1:0] trig_amp,
  input  logic signed [DATA_W-1:0] baseline,
  input  logic                     sample_en,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     pulse_done
);

  // Two guard bits let baseline + acc (+ noise) be formed without wrap.
  localparam int AW      = DATA_W + 2;
  localparam int RISE_SH = $clog2(RISE_LEN);
  localparam int CNT_W   = (RISE_SH > 0) ? RISE_SH : 1;
  localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_LEN - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  pg_state_t state, state_next;
  logic signed [AW-1:0] acc, acc_next;
  logic signed [AW-1:0] amp, amp_next;
  logic signed [AW-1:0] step, step_next;
  logic [CNT_W-1:0] rise_cnt, rise_cnt_next;
  logic done_next;

  logic signed [AW-1:0] trig_amp_ext;
  logic signed [AW-1:0] base_ext;
  logic signed [AW-1:0] decay_d;
  logic signed [AW-1:0] noise_ext;
  logic signed [AW-1:0] sum;
  logic signed [DATA_W-1:0] sat_val;

  assign trig_ack     = trig && (state == IDLE) && !reset;
  assign trig_amp_ext = {{2{trig_amp[DATA_W-1]}}, trig_amp};
  assign base_ext     = {{2{baseline[DATA_W-1]}}, baseline};
  assign decay_d      = acc >>> DECAY_SHIFT;

`ifdef V3_PULSE_GEN_NOISE_EN
  logic [15:0] lfsr_q;

  v3_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (sample_en),
    .q     (lfsr_q)
  );

  assign noise_ext = {{(AW-NOISE_BITS){lfsr_q[NOISE_BITS-1]}}, lfsr_q[NOISE_BITS-1:0]};
`else
  assign noise_ext = '0;
`endif

  // Next-state and accumulator update. The IDLE accept happens regardless of
  // sample_en; RISE/DECAY only move on a sample strobe.
  always_comb begin
    state_next    = state;
    acc_next      = acc;
    amp_next      = amp;
    step_next     = step;
    rise_cnt_next = rise_cnt;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        if (trig_ack) begin
          amp_next      = trig_amp_ext;
          step_next     = trig_amp_ext >>> RISE_SH;
          rise_cnt_next = '0;
          state_next    = RISE;
        end
      end
      RISE: begin
        if (sample_en) begin
          // The last rise sample loads amp exactly so the truncated step
          // leaves no residue at the peak.
          if (rise_cnt == RISE_LAST) begin
            acc_next   = amp;
            state_next = DECAY;
          end else begin
            acc_next      = acc + step;
            rise_cnt_next = rise_cnt + 1'b1;
          end
        end
      end
      DECAY: begin
        if (sample_en) begin
          // A decrement of 0 or -1 means the tail can no longer shrink.
          if ((decay_d == '0) || (decay_d == '1)) begin
            acc_next   = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            acc_next = acc - decay_d;
          end
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
      end
    endcase
  end

  // Output uses this cycle's new accumulator value, then clamps to DATA_W.
  always_comb begin
    sum = base_ext + acc_next + noise_ext;
    if (sum > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (sum < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_val = sum[DATA_W-1:0];
    end
  end

  // busy follows the registered state, so it falls together with pulse_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      amp        <= '0;
      step       <= '0;
      rise_cnt   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      pulse_done <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      amp        <= amp_next;
      step       <= step_next;
      rise_cnt   <= rise_cnt_next;
      out_valid  <= sample_en;
      busy       <= (state_next != IDLE);
      pulse_done <= done_next;
      if (sample_en) begin
        out_data <= sat_val;
      end
    end
  end

endmodule

// File: tb/tb_v3_pulse_gen.sv
// tb_v3_pulse_gen
// Directed bench for v3_pulse_gen with default parameters (DATA_W=16,
// RISE_LEN=4, DECAY_SHIFT=4). Table-driven vectors cover reset, the
// simultaneous trig/sample case, zero amplitude and the start of a basic
// pulse; hand-written sequences cover decay tails, saturation, busy
// rejection, gapped strobes and reset mid-decay.
module tb_v3_pulse_gen;

  logic clk = 1'b0;
  logic reset;
  logic trig;
  logic trig_ack;
  logic signed [15:0] trig_amp;
  logic signed [15:0] baseline;
  logic sample_en;
  logic signed [15:0] out_data;
  logic out_valid;
  logic busy;
  logic pulse_done;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  v3_pulse_gen dut (
    .clk        (clk),
    .reset      (reset),
    .trig       (trig),
    .trig_ack   (trig_ack),
    .trig_amp   (trig_amp),
    .baseline   (baseline),
    .sample_en  (sample_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .pulse_done (pulse_done)
  );

  typedef struct {
    logic rst;
    logic trg;
    int   amp;
    int   base;
    logic se;
    logic e_ack;
    int   e_data;
    logic e_valid;
    logic e_busy;
    logic e_done;
  } vec_t;

  vec_t vecs[15];

  function automatic int satf(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic t, input int amp,
                               input int base, input logic se);
    reset     = rst;
    trig      = t;
    trig_amp  = 16'(amp);
    baseline  = 16'(base);
    sample_en = se;
  endtask

  // Called at a falling edge: drive, check the combinational ack, clock once,
  // then check the registered outputs at the next falling edge.
  task automatic doCycle(input logic rst, input logic t, input int amp, input int base,
                         input logic se, input logic e_ack, input int e_data,
                         input logic e_valid, input logic e_busy, input logic e_done,
                         input string tag);
    applyStimulus(rst, t, amp, base, se);
    #1;
    checkOutput({tag, " trig_ack"}, trig_ack, e_ack);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " out_data"}, out_data, e_data);
    checkOutput({tag, " out_valid"}, out_valid, e_valid);
    checkOutput({tag, " busy"}, busy, e_busy);
    checkOutput({tag, " pulse_done"}, pulse_done, e_done);
  endtask

  // Runs the decay from acc0 with sample_en every cycle, predicting each
  // sample from the decay rule, until the terminating sample.
  task automatic runPulseTail(input int acc0, input int base, input logic t, input string tag);
    int acc;
    int d;
    logic done;
    acc = acc0;
    for (int n = 0; n < 400; n++) begin
      d = acc >>> 4;
      done = (d == 0) || (d == -1);
      acc = done ? 0 : acc - d;
      doCycle(1'b0, t, 0, base, 1'b1, 1'b0, satf(base + acc), 1'b1, !done, done, tag);
      if (done) begin
        checkOutput({tag, " ack after done"}, trig_ack, t);
        return;
      end
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: pulse_done never seen, expected within 400 samples", tag);
  endtask

  initial begin
    int rise_vals[7];
    int sat_vals[4];
    int gap_vals[6];

    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset with trig pending, then zero-amplitude pulse accepted together
    // with a sample strobe, then the start of the basic pulse.
    vecs[0] = '{1'b1, 1'b1, 1000, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 0, 7, 1'b1, 1'b1, 7, 1'b1, 1'b1, 1'b0};
    for (int i = 2; i <= 5; i++) vecs[i] = '{1'b0, 1'b0, 0, 7, 1'b1, 1'b0, 7, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 0, 7, 1'b1, 1'b0, 7, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1000, 0, 1'b0, 1'b1, 7, 1'b0, 1'b1, 1'b0};
    rise_vals = '{250, 500, 750, 1000, 938, 880, 825};
    for (int i = 0; i < 7; i++)
      vecs[8+i] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, rise_vals[i], 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 15; i++) begin
      doCycle(vecs[i].rst, vecs[i].trg, vecs[i].amp, vecs[i].base, vecs[i].se,
              vecs[i].e_ack, vecs[i].e_data, vecs[i].e_valid, vecs[i].e_busy,
              vecs[i].e_done, $sformatf("vec%0d", i));
    end
    runPulseTail(825, 0, 1'b0, "basic tail");

    // Saturation against the positive rail.
    doCycle(1'b0, 1'b1, 1000, 32000, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, "sat accept");
    sat_vals = '{32250, 32500, 32750, 32767};
    for (int i = 0; i < 4; i++)
      doCycle(1'b0, 1'b0, 0, 32000, 1'b1, 1'b0, sat_vals[i], 1'b1, 1'b1, 1'b0,
              $sformatf("sat rise%0d", i));
    runPulseTail(1000, 32000, 1'b0, "sat tail");

    // trig held for the whole pulse: never acked until the pulse has ended.
    doCycle(1'b0, 1'b1, 500, 0, 1'b0, 1'b1, 32000, 1'b0, 1'b1, 1'b0, "busy accept");
    for (int i = 0; i < 4; i++)
      doCycle(1'b0, 1'b1, -3000, 0, 1'b1, 1'b0, 125 * (i + 1), 1'b1, 1'b1, 1'b0,
              $sformatf("busy rise%0d", i));
    runPulseTail(500, 0, 1'b1, "busy tail");
    doCycle(1'b0, 1'b1, 300, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, "busy reaccept");
    doCycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "busy reset");

    // sample_en every third cycle, negative amplitude.
    doCycle(1'b0, 1'b1, -800, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, "gap accept");
    gap_vals = '{-200, -400, -600, -800, -750, -703};
    for (int i = 0; i < 6; i++) begin
      doCycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, gap_vals[i], 1'b1, 1'b1, 1'b0,
              $sformatf("gap strobe%0d", i));
      for (int k = 0; k < 2; k++)
        doCycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, gap_vals[i], 1'b0, 1'b1, 1'b0,
                $sformatf("gap hold%0d.%0d", i, k));
    end
    runPulseTail(-703, 0, 1'b0, "gap tail");

    // Reset on the second decay sample.
    doCycle(1'b0, 1'b1, 1000, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, "rst accept");
    for (int i = 0; i < 4; i++)
      doCycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, rise_vals[i], 1'b1, 1'b1, 1'b0,
              $sformatf("rst rise%0d", i));
    doCycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 938, 1'b1, 1'b1, 1'b0, "rst decay0");
    doCycle(1'b1, 1'b1, 1000, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, "rst mid decay");
    doCycle(1'b0, 1'b1, 1000, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, "rst reaccept");
    doCycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "rst clean");

`ifdef V3_PULSE_GEN_NOISE_EN
    begin
      int first_run[12];
      for (int r = 0; r < 2; r++) begin
        applyStimulus(1'b1, 1'b0, 0, 100, 1'b0);
        @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 12; s++) begin
          applyStimulus(1'b0, (s == 0), 0, 100, 1'b1);
          @(posedge clk);
          @(negedge clk);
          checkOutput($sformatf("noise range r%0d s%0d", r, s),
                      (out_data >= 96 && out_data <= 103), 1);
          if (r == 0) first_run[s] = int'(out_data);
          else checkOutput($sformatf("noise repeat s%0d", s), out_data, first_run[s]);
        end
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
